// File: rtl/mport_ram.sv
// rtl/mport_ram.sv - N-port read-first RAM with valid/ready request and response streams; MPORT_RAM_OUT_REG_EN adds a second output register
module mport_ram #(
  parameter int W_DATA = 16,
  parameter int W_ADDR = 10,
  parameter int DEPTH  = 1024,
  parameter int N_PORT = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_PORT-1:0]                      req_tvalid,
  output logic [N_PORT-1:0]                      req_tready,
  input  logic [N_PORT-1:0][1+W_DATA+W_ADDR-1:0] req_tdata,
  output logic [N_PORT-1:0]                      dout_tvalid,
  input  logic [N_PORT-1:0]                      dout_tready,
  output logic [N_PORT-1:0][W_DATA-1:0]          dout_tdata,
  output logic [N_PORT-1:0]                      collision_o
);

  localparam logic [W_ADDR:0] DEPTH_L = (W_ADDR+1)'(DEPTH);

  logic [W_DATA-1:0] mem [DEPTH];

  logic [N_PORT-1:0]              is_wr;
  logic [N_PORT-1:0][W_DATA-1:0]  wdata;
  logic [N_PORT-1:0][W_ADDR-1:0]  addr;
  logic [N_PORT-1:0]              in_range;
  logic [N_PORT-1:0]              acc;
  logic [N_PORT-1:0]              wr_acc;
  logic [N_PORT-1:0]              rd_acc;
  logic [N_PORT-1:0][W_DATA-1:0]  rd_word;
  logic [N_PORT-1:0]              slot_free;
  logic [N_PORT-1:0]              coll_nxt;
  logic [N_PORT-1:0]              s1_valid;
  logic [N_PORT-1:0][W_DATA-1:0]  s1_data;

  // Request field split, handshake qualification and pre-edge (read-first) memory lookup
  always_comb begin
    is_wr    = '0;
    wdata    = '0;
    addr     = '0;
    in_range = '0;
    acc      = '0;
    rd_word  = '0;
    for (int p = 0; p < N_PORT; p++) begin
      is_wr[p]    = req_tdata[p][W_ADDR+W_DATA];
      wdata[p]    = req_tdata[p][W_ADDR +: W_DATA];
      addr[p]     = req_tdata[p][W_ADDR-1:0];
      in_range[p] = ({1'b0, addr[p]} < DEPTH_L);
      acc[p]      = req_tvalid[p] & req_tready[p];
      rd_word[p]  = in_range[p] ? mem[addr[p]] : '0;
    end
    wr_acc = acc & is_wr;
    rd_acc = acc & ~is_wr;
  end

  // Ready depends only on this port's own output slot; reset blocks all requests
  always_comb begin
    req_tready = '0;
    for (int p = 0; p < N_PORT; p++) begin
      req_tready[p] = !rst && (!req_tvalid[p] || slot_free[p]);
    end
  end

  // Writes applied highest port first so the lowest-index port's value lands last and wins
  always_ff @(posedge clk) begin
    for (int p = N_PORT - 1; p >= 0; p--) begin
      if (wr_acc[p] && in_range[p]) begin
        mem[addr[p]] <= wdata[p];
      end
    end
  end

  // A port loses when any lower-index port writes the same address at the same edge
  always_comb begin
    coll_nxt = '0;
    for (int p = 0; p < N_PORT; p++) begin
      for (int q = 0; q < N_PORT; q++) begin
        if (q < p && wr_acc[p] && wr_acc[q] && addr[p] == addr[q]) begin
          coll_nxt[p] = 1'b1;
        end
      end
    end
  end

  // Collision flags are single-cycle pulses following the contended edge
  always_ff @(posedge clk) begin
    if (rst) begin
      collision_o <= '0;
    end else begin
      collision_o <= coll_nxt;
    end
  end

`ifdef MPORT_RAM_OUT_REG_EN
  logic [N_PORT-1:0]             s2_valid;
  logic [N_PORT-1:0][W_DATA-1:0] s2_data;

  // Stage 1 may still take a read while stage 2 is stalled, as long as stage 1 is empty
  always_comb begin
    slot_free = ~s2_valid | dout_tready | ~s1_valid;
  end

  // Two-deep read pipeline; both stages advance together when stage 2 drains or is empty
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= '0;
      s2_valid <= '0;
    end else begin
      for (int p = 0; p < N_PORT; p++) begin
        if (!s2_valid[p] || dout_tready[p]) begin
          s2_valid[p] <= s1_valid[p];
          s2_data[p]  <= s1_data[p];
          s1_valid[p] <= rd_acc[p];
          if (rd_acc[p]) begin
            s1_data[p] <= rd_word[p];
          end
        end else if (!s1_valid[p]) begin
          s1_valid[p] <= rd_acc[p];
          if (rd_acc[p]) begin
            s1_data[p] <= rd_word[p];
          end
        end
      end
    end
  end

  // Responses leave from stage 2
  always_comb begin
    dout_tvalid = s2_valid;
    dout_tdata  = s2_data;
  end
`else
  // Single output slot frees when empty or being consumed this cycle
  always_comb begin
    slot_free = ~s1_valid | dout_tready;
  end

  // One-deep read register; holds while stalled since no read is accepted then
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= '0;
    end else begin
      for (int p = 0; p < N_PORT; p++) begin
        if (rd_acc[p]) begin
          s1_valid[p] <= 1'b1;
          s1_data[p]  <= rd_word[p];
        end else if (dout_tready[p]) begin
          s1_valid[p] <= 1'b0;
        end
      end
    end
  end

  // Responses leave from stage 1
  always_comb begin
    dout_tvalid = s1_valid;
    dout_tdata  = s1_data;
  end
`endif

endmodule

// File: tb/tb_mport_ram.sv
// tb/tb_mport_ram.sv - self-checking bench for mport_ram (two ports, DEPTH 1000 to reach out-of-range addresses)
module tb_mport_ram;

`ifdef MPORT_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk;
  logic            rst;
  logic [1:0]      req_tvalid;
  logic [1:0]      req_tready;
  logic [1:0][26:0] req_tdata;
  logic [1:0]      dout_tvalid;
  logic [1:0]      dout_tready;
  logic [1:0][15:0] dout_tdata;
  logic [1:0]      collision_o;

  int n_chk;
  int n_fail;

  mport_ram #(.W_DATA(16), .W_ADDR(10), .DEPTH(1000), .N_PORT(2)) dut (
    .clk(clk),
    .rst(rst),
    .req_tvalid(req_tvalid),
    .req_tready(req_tready),
    .req_tdata(req_tdata),
    .dout_tvalid(dout_tvalid),
    .dout_tready(dout_tready),
    .dout_tdata(dout_tdata),
    .collision_o(collision_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        v0;
    logic        w0;
    logic [15:0] d0;
    logic [9:0]  a0;
    logic        v1;
    logic        w1;
    logic [15:0] d1;
    logic [9:0]  a1;
    logic [1:0]  ecoll;
    logic [1:0]  evld;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int p, input logic [9:0] a, input logic [15:0] d);
    req_tvalid    = '0;
    req_tvalid[p] = 1'b1;
    req_tdata[p]  = {1'b1, d, a};
    cyc();
    req_tvalid = '0;
  endtask

  task automatic read_chk(input int p, input logic [9:0] a, input logic [15:0] exp, input string nm);
    dout_tready   = 2'b11;
    req_tvalid    = '0;
    req_tvalid[p] = 1'b1;
    req_tdata[p]  = {1'b0, 16'h0, a};
    for (int k = 1; k <= LAT; k++) begin
      cyc();
      req_tvalid = '0;
    end
    chk({nm, "_vld"}, 32'(dout_tvalid[p]), 32'd1);
    chk(nm, 32'(dout_tdata[p]), 32'(exp));
  endtask

  initial begin
    int got;
    int n;
    int idx;
    n_chk       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    req_tvalid  = 2'b11;
    req_tdata[0] = {1'b1, 16'hDEAD, 10'd60};
    req_tdata[1] = {1'b0, 16'h0, 10'd61};
    dout_tready = 2'b11;

    tv[0]  = '{1'b1, 1'b1, 16'hBEEF, 10'd5,    1'b0, 1'b0, 16'h0,    10'd0,    2'b00, 2'b00, 16'h0,    16'h0};
    tv[1]  = '{1'b0, 1'b0, 16'h0,    10'd0,    1'b1, 1'b0, 16'h0,    10'd5,    2'b00, 2'b10, 16'h0,    16'hBEEF};
    tv[2]  = '{1'b1, 1'b1, 16'h1111, 10'd7,    1'b1, 1'b1, 16'h2222, 10'd7,    2'b10, 2'b00, 16'h0,    16'h0};
    tv[3]  = '{1'b1, 1'b0, 16'h0,    10'd7,    1'b0, 1'b0, 16'h0,    10'd0,    2'b00, 2'b01, 16'h1111, 16'h0};
    tv[4]  = '{1'b1, 1'b1, 16'hAAAA, 10'd3,    1'b0, 1'b0, 16'h0,    10'd0,    2'b00, 2'b00, 16'h0,    16'h0};
    tv[5]  = '{1'b1, 1'b1, 16'h5555, 10'd3,    1'b1, 1'b0, 16'h0,    10'd3,    2'b00, 2'b10, 16'h0,    16'hAAAA};
    tv[6]  = '{1'b1, 1'b0, 16'h0,    10'd3,    1'b1, 1'b0, 16'h0,    10'd5,    2'b00, 2'b11, 16'h5555, 16'hBEEF};
    tv[7]  = '{1'b1, 1'b1, 16'h0A0A, 10'd20,   1'b1, 1'b1, 16'h0B0B, 10'd21,   2'b00, 2'b00, 16'h0,    16'h0};
    tv[8]  = '{1'b1, 1'b0, 16'h0,    10'd21,   1'b1, 1'b0, 16'h0,    10'd20,   2'b00, 2'b11, 16'h0B0B, 16'h0A0A};
    tv[9]  = '{1'b0, 1'b0, 16'h0,    10'd0,    1'b1, 1'b1, 16'h7777, 10'd999,  2'b00, 2'b00, 16'h0,    16'h0};
    tv[10] = '{1'b1, 1'b0, 16'h0,    10'd999,  1'b1, 1'b1, 16'h1234, 10'd1000, 2'b00, 2'b01, 16'h7777, 16'h0};
    tv[11] = '{1'b1, 1'b0, 16'h0,    10'd1000, 1'b1, 1'b0, 16'h0,    10'd1023, 2'b00, 2'b11, 16'h0,    16'h0};

    // reset state: requests blocked, outputs idle
    @(negedge clk);
    chk("rst_req_ready", 32'(req_tready), 32'd0);
    cyc();
    chk("rst_dout_valid", 32'(dout_tvalid), 32'd0);
    chk("rst_collision", 32'(collision_o), 32'd0);
    chk("rst_req_ready2", 32'(req_tready), 32'd0);
    rst        = 1'b0;
    req_tvalid = '0;
    cyc();

    // table: one request cycle per row, then watch LAT+1 edges
    for (int i = 0; i < 12; i++) begin
      req_tvalid   = {tv[i].v1, tv[i].v0};
      req_tdata[0] = {tv[i].w0, tv[i].d0, tv[i].a0};
      req_tdata[1] = {tv[i].w1, tv[i].d1, tv[i].a1};
      dout_tready  = 2'b11;
      #1;
      chk($sformatf("tv%0d_ready", i), 32'(req_tready), 32'd3);
      for (int k = 1; k <= LAT + 1; k++) begin
        cyc();
        req_tvalid = '0;
        chk($sformatf("tv%0d_coll_k%0d", i, k), 32'(collision_o),
            (k == 1) ? 32'(tv[i].ecoll) : 32'd0);
        chk($sformatf("tv%0d_vld_k%0d", i, k), 32'(dout_tvalid),
            (k == LAT) ? 32'(tv[i].evld) : 32'd0);
        if (k == LAT && tv[i].evld[0]) chk($sformatf("tv%0d_dout0", i), 32'(dout_tdata[0]), 32'(tv[i].e0));
        if (k == LAT && tv[i].evld[1]) chk($sformatf("tv%0d_dout1", i), 32'(dout_tdata[1]), 32'(tv[i].e1));
      end
    end

    // stall on port 0 while port 1 overwrites the same word
    wr(0, 10'd9, 16'h9999);
    dout_tready   = 2'b10;
    req_tvalid    = 2'b01;
    req_tdata[0]  = {1'b0, 16'h0, 10'd9};
    got = 0;
    for (int k = 0; k < 4 && got == 0; k++) begin
      cyc();
      if (!req_tready[0]) got = 1;
    end
    chk("stall_ready_drop", 32'(got), 32'd1);
    for (int k = 0; k < 4; k++) begin
      req_tvalid   = 2'b11;
      req_tdata[1] = {1'b1, 16'h6666, 10'd9};
      #1;
      chk($sformatf("stall_p1_ready_%0d", k), 32'(req_tready[1]), 32'd1);
      cyc();
      chk($sformatf("stall_p0_ready_%0d", k), 32'(req_tready[0]), 32'd0);
      chk($sformatf("stall_p0_vld_%0d", k), 32'(dout_tvalid[0]), 32'd1);
      chk($sformatf("stall_p0_data_%0d", k), 32'(dout_tdata[0]), 32'h9999);
    end
    req_tvalid  = '0;
    dout_tready = 2'b11;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      if (dout_tvalid[0]) begin
        n++;
        chk($sformatf("stall_drain_data_%0d", k), 32'(dout_tdata[0]), 32'h9999);
      end
      cyc();
    end
    chk("stall_drain_count", 32'(n), 32'(LAT));
    read_chk(0, 10'd9, 16'h6666, "stall_p1_write_landed");

    // eight back-to-back reads on port 0
    for (int i = 0; i < 8; i++) wr(0, 10'(100 + i), 16'hC000 + 16'(i));
    dout_tready = 2'b11;
    for (int j = 0; j < 8 + LAT; j++) begin
      if (j < 8) begin
        req_tvalid   = 2'b01;
        req_tdata[0] = {1'b0, 16'h0, 10'(100 + j)};
        #1;
        chk($sformatf("b2b_ready_%0d", j), 32'(req_tready[0]), 32'd1);
      end else begin
        req_tvalid = '0;
      end
      cyc();
      idx = j - (LAT - 1);
      if (idx >= 0 && idx < 8) begin
        chk($sformatf("b2b_vld_%0d", idx), 32'(dout_tvalid[0]), 32'd1);
        chk($sformatf("b2b_data_%0d", idx), 32'(dout_tdata[0]), 32'hC000 + 32'(idx));
      end else begin
        chk($sformatf("b2b_idle_%0d", j), 32'(dout_tvalid[0]), 32'd0);
      end
    end
    req_tvalid = '0;

    // reset with two reads in flight; memory survives, writes during reset ignored
    wr(0, 10'd50, 16'h5050);
    dout_tready  = 2'b00;
    req_tvalid   = 2'b11;
    req_tdata[0] = {1'b0, 16'h0, 10'd5};
    req_tdata[1] = {1'b0, 16'h0, 10'd7};
    cyc();
    rst          = 1'b1;
    req_tdata[0] = {1'b1, 16'hDEAD, 10'd50};
    req_tdata[1] = {1'b1, 16'hDEAD, 10'd50};
    #1;
    chk("rst2_req_ready", 32'(req_tready), 32'd0);
    cyc();
    chk("rst2_dout_valid", 32'(dout_tvalid), 32'd0);
    chk("rst2_collision", 32'(collision_o), 32'd0);
    rst         = 1'b0;
    req_tvalid  = '0;
    dout_tready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("rst2_no_resp_%0d", k), 32'(dout_tvalid), 32'd0);
    end
    read_chk(0, 10'd50, 16'h5050, "rst2_mem_kept");
    read_chk(1, 10'd7, 16'h1111, "rst2_mem7_kept");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
